ex_pipeline_controller: RTL and testbench
=========================================

// Module: ex_pipeline_controller
// PURPOSE
//   Sequences the EX stage of the 32-bit pipeline. It holds IF/OF/EX frozen while a
//   multi-cycle ALU op (mul/div/mod) runs, and inserts a bubble on a load-use hazard.
//   On a taken branch it steers the PC to BranchPC and flushes the wrong-path
//   instructions. Sits between EX, the pipeline registers and the fetch unit.
// PARAMETERS
//   MC_LAT   4   cycles a multi-cycle ALU op occupies the ALU (legal >=1)
//   CNT_W    32  width of perf counters (only with EX_PERF_COUNT_EN)
// PORTS
//   clk              in   1      pipeline clock, rising edge
//   reset            in   1      asynchronous, active-high reset
//   ex_valid         in   1      valid instruction present in EX
//   ex_is_multicycle in   1      EX AluSignal decodes to mul/div/mod
//   IsBranchTaken    in   1      branch outcome from EX (qualified by ex_valid)
//   BranchPC         in   32     branch/ret target from EX
//   ld_use_hazard    in   1      OF instr reads rd of a load currently in EX
//   stall            out  1      hold PC, IF/OF and OF/EX pipeline registers
//   bubble_ex        out  1      load NOP into EX/MA register this cycle
//   flush_if_of      out  1      squash IF/OF and OF/EX contents this cycle
//   pc_sel           out  1      1: fetch uses pc_target, 0: PC+4
//   pc_target        out  32     registered redirect address
//   alu_start        out  1      1-cycle start pulse to multi-cycle ALU
//   ex_done          out  1      multi-cycle result valid, EX may advance
// BEHAVIOUR
//   - States: IDLE, MC_BUSY, REDIRECT. Reset: IDLE; all outputs 0; pc_target 0; cnt 0.
//   - Priority in IDLE (same cycle): branch > multi-cycle > load-use.
//   - IDLE, ex_valid&IsBranchTaken: capture pc_target<=BranchPC; next state REDIRECT.
//   - REDIRECT (exactly 1 cycle): pc_sel=1, flush_if_of=1, stall=0; then IDLE.
//     A branch in EX that is itself multi-cycle is illegal (decoder guarantees).
//   - IDLE, ex_valid&ex_is_multicycle&!IsBranchTaken: next MC_BUSY, cnt<=MC_LAT-1.
//   - MC_BUSY: alu_start=1 in first MC_BUSY cycle only; stall=1 while cnt!=0,
//     cnt decrements each cycle; when cnt==0: ex_done=1, stall=0, next IDLE.
//   - MC_LAT=1: MC_BUSY lasts one cycle with alu_start=ex_done=1, no stall.
//   - IDLE, ld_use_hazard, no branch/multicycle: stall=1 and bubble_ex=1 for that
//     cycle only (Moore on registered hazard flag: asserted the cycle after
//     ld_use_hazard is sampled, cleared next cycle; back-to-back requests re-arm).
//   - ld_use_hazard ignored during MC_BUSY (pipeline already frozen) and REDIRECT
//     (offending instr is flushed).
//   - stall, bubble_ex, flush_if_of never asserted together except stall+bubble_ex.
//   - Async reset mid-MC_BUSY/REDIRECT: immediately IDLE, outputs 0, no ex_done.
//   - cnt width = $clog2(MC_LAT)+1; no wrap (loaded only from IDLE).
// CONFIGURATION
//   EX_PERF_COUNT_EN defined: adds outputs stall_cycles[CNT_W-1:0] (+1 per cycle
//   stall=1) and flush_count[CNT_W-1:0] (+1 per REDIRECT entry); both saturate at
//   all-ones, reset to 0. Undefined: ports and counters absent, no other change.
// TESTING
//   1 reset held, toggle all inputs -> every output 0; release -> state IDLE.
//   2 MC_LAT=4, mul in EX -> alu_start 1 cycle, stall 3 cycles, ex_done on 4th.
//   3 branch taken, BranchPC=0x0000_0040 -> next cycle pc_sel=1,
//     pc_target=0x40, flush_if_of=1 for exactly 1 cycle, then IDLE.
//   4 branch+ld_use_hazard+multicycle same cycle -> only REDIRECT; no stall/start.
//   5 ld_use_hazard one cycle -> stall=bubble_ex=1 for exactly one cycle.
//   6 reset asserted mid-MC_BUSY cnt=2 -> outputs 0 at once; with
//     EX_PERF_COUNT_EN, counters read 0 after reset.

Source files
------------

// File: rtl/ex_pipeline_controller.sv
// EX-stage sequencer for the 32-bit pipeline.
// Freezes IF/OF/EX while a multi-cycle ALU op (mul/div/mod) runs, inserts a
// bubble on a load-use hazard, and redirects fetch and flushes the wrong path
// on a taken branch.
// Optional build macro: EX_PERF_COUNT_EN adds the saturating stall_cycles and
// flush_count outputs (width CNT_W).
module ex_pipeline_controller #(
  parameter int MC_LAT = 4
`ifdef EX_PERF_COUNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_is_multicycle,
  input  logic        IsBranchTaken,
  input  logic [31:0] BranchPC,
  input  logic        ld_use_hazard,
  output logic        stall,
  output logic        bubble_ex,
  output logic        flush_if_of,
  output logic        pc_sel,
  output logic [31:0] pc_target,
  output logic        alu_start,
  output logic        ex_done
`ifdef EX_PERF_COUNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  // Countdown is loaded with MC_LAT-1 and only ever decrements to zero.
  localparam int CW = $clog2(MC_LAT) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MC_LAT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MC_BUSY  = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hz_q, hz_d;
  logic [31:0]   pc_target_q, pc_target_d;
  logic          take_branch;
  logic          take_mc;

  // Branch wins over multi-cycle, which wins over load-use.
  assign take_branch = ex_valid & IsBranchTaken;
  assign take_mc     = ex_valid & ex_is_multicycle & ~IsBranchTaken;

  // State, countdown, hazard flag and redirect target registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hz_q        <= 1'b0;
      pc_target_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hz_q        <= hz_d;
      pc_target_q <= pc_target_d;
    end
  end

  // Next-state logic; the hazard flag is only armed from IDLE with nothing
  // of higher priority pending, so it is ignored in MC_BUSY and REDIRECT.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hz_d        = 1'b0;
    pc_target_d = pc_target_q;
    case (state_q)
      IDLE: begin
        if (take_branch) begin
          state_d     = REDIRECT;
          pc_target_d = BranchPC;
        end else if (take_mc) begin
          state_d = MC_BUSY;
          cnt_d   = CNT_LOAD;
        end else begin
          hz_d = ld_use_hazard;
        end
      end
      MC_BUSY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    stall       = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_of = 1'b0;
    pc_sel      = 1'b0;
    alu_start   = 1'b0;
    ex_done     = 1'b0;
    case (state_q)
      IDLE: begin
        stall     = hz_q;
        bubble_ex = hz_q;
      end
      MC_BUSY: begin
        // cnt equals its load value only in the first busy cycle.
        alu_start = (cnt_q == CNT_LOAD);
        stall     = (cnt_q != '0);
        ex_done   = (cnt_q == '0);
      end
      REDIRECT: begin
        pc_sel      = 1'b1;
        flush_if_of = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_target = pc_target_q;

`ifdef EX_PERF_COUNT_EN
  logic [CNT_W-1:0] stall_cycles_q;
  logic [CNT_W-1:0] flush_count_q;

  // Saturating counters: stalled cycles and REDIRECT entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stall && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      end
      if ((state_q == IDLE) && (state_d == REDIRECT) && (flush_count_q != '1)) begin
        flush_count_q <= flush_count_q + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_ex_pipeline_controller.sv
// Directed bench for ex_pipeline_controller (MC_LAT = 4).
// Output vector order: {stall, bubble_ex, flush_if_of, pc_sel, alu_start, ex_done}.
module tb_ex_pipeline_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid = 1'b0;
  logic        ex_is_multicycle = 1'b0;
  logic        IsBranchTaken = 1'b0;
  logic [31:0] BranchPC = 32'd0;
  logic        ld_use_hazard = 1'b0;
  logic        stall, bubble_ex, flush_if_of, pc_sel, alu_start, ex_done;
  logic [31:0] pc_target;
`ifdef EX_PERF_COUNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif
  logic [5:0]  outs;

  int pass_cnt = 0;
  int total_cnt = 0;

  assign outs = {stall, bubble_ex, flush_if_of, pc_sel, alu_start, ex_done};

  always #5 clk = ~clk;

  ex_pipeline_controller #(.MC_LAT(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .ex_valid         (ex_valid),
    .ex_is_multicycle (ex_is_multicycle),
    .IsBranchTaken    (IsBranchTaken),
    .BranchPC         (BranchPC),
    .ld_use_hazard    (ld_use_hazard),
    .stall            (stall),
    .bubble_ex        (bubble_ex),
    .flush_if_of      (flush_if_of),
    .pc_sel           (pc_sel),
    .pc_target        (pc_target),
    .alu_start        (alu_start),
    .ex_done          (ex_done)
`ifdef EX_PERF_COUNT_EN
    ,
    .stall_cycles     (stall_cycles),
    .flush_count      (flush_count)
`endif
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_valid = 1'b0;
    ex_is_multicycle = 1'b0;
    IsBranchTaken = 1'b0;
    ld_use_hazard = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] v;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v = 4'(i * 5 + 3);
      {ex_valid, ex_is_multicycle, IsBranchTaken, ld_use_hazard} = v;
      BranchPC = 32'h1234_0000 + 32'(i);
      step();
      total_cnt++;
      if (outs !== 6'b000000) $display("FAIL reset_outs cyc%0d: got %b want 000000", i, outs);
      else pass_cnt++;
      total_cnt++;
      if (pc_target !== 32'd0) $display("FAIL reset_pc_target cyc%0d: got %h want 00000000", i, pc_target);
      else pass_cnt++;
    end
    clear_inputs();
    reset = 1'b0;
    step();
    total_cnt++;
    if (outs !== 6'b000000) $display("FAIL reset_release: got %b want 000000", outs);
    else pass_cnt++;
    // A lone hazard right after release proves the FSM sits in IDLE.
    ld_use_hazard = 1'b1;
    step();
    ld_use_hazard = 1'b0;
    total_cnt++;
    if (outs !== 6'b110000) $display("FAIL reset_idle_hazard: got %b want 110000", outs);
    else pass_cnt++;
    step();
    $display("test_reset done");
  endtask

  task automatic test_multicycle();
    logic [5:0] exp_seq [5];
    exp_seq = '{6'b100010, 6'b100000, 6'b100000, 6'b000001, 6'b000000};
    ex_valid = 1'b1;
    ex_is_multicycle = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) begin
        clear_inputs();
        ld_use_hazard = 1'b1;   // must be ignored while busy
      end
      if (i == 2) ld_use_hazard = 1'b0;
      total_cnt++;
      if (outs !== exp_seq[i]) $display("FAIL multicycle cyc%0d: got %b want %b", i, outs, exp_seq[i]);
      else pass_cnt++;
    end
    $display("test_multicycle done");
  endtask

  task automatic test_branch();
    ex_valid = 1'b1;
    IsBranchTaken = 1'b1;
    BranchPC = 32'h0000_0040;
    step();
    clear_inputs();
    BranchPC = 32'hDEAD_BEEF;
    total_cnt++;
    if (outs !== 6'b001100) $display("FAIL branch_redirect: got %b want 001100", outs);
    else pass_cnt++;
    total_cnt++;
    if (pc_target !== 32'h0000_0040) $display("FAIL branch_target: got %h want 00000040", pc_target);
    else pass_cnt++;
    step();
    total_cnt++;
    if (outs !== 6'b000000) $display("FAIL branch_one_cycle: got %b want 000000", outs);
    else pass_cnt++;
    // Taken flag without ex_valid is not a branch.
    IsBranchTaken = 1'b1;
    step();
    IsBranchTaken = 1'b0;
    total_cnt++;
    if (outs !== 6'b000000) $display("FAIL branch_unqualified: got %b want 000000", outs);
    else pass_cnt++;
    total_cnt++;
    if (pc_target !== 32'h0000_0040) $display("FAIL branch_target_hold: got %h want 00000040", pc_target);
    else pass_cnt++;
    $display("test_branch done");
  endtask

  task automatic test_priority();
    logic [5:0] exp_seq [5];
    ex_valid = 1'b1;
    IsBranchTaken = 1'b1;
    ex_is_multicycle = 1'b1;
    ld_use_hazard = 1'b1;
    BranchPC = 32'h0000_0100;
    step();
    ex_valid = 1'b0;
    IsBranchTaken = 1'b0;
    ex_is_multicycle = 1'b0;     // hazard kept high into REDIRECT
    total_cnt++;
    if (outs !== 6'b001100) $display("FAIL prio_branch: got %b want 001100", outs);
    else pass_cnt++;
    total_cnt++;
    if (pc_target !== 32'h0000_0100) $display("FAIL prio_target: got %h want 00000100", pc_target);
    else pass_cnt++;
    step();
    ld_use_hazard = 1'b0;
    total_cnt++;
    if (outs !== 6'b000000) $display("FAIL prio_after_redirect: got %b want 000000", outs);
    else pass_cnt++;
    step();
    total_cnt++;
    if (outs !== 6'b000000) $display("FAIL prio_no_late_stall: got %b want 000000", outs);
    else pass_cnt++;
    // Multi-cycle beats load-use.
    exp_seq = '{6'b100010, 6'b100000, 6'b100000, 6'b000001, 6'b000000};
    ex_valid = 1'b1;
    ex_is_multicycle = 1'b1;
    ld_use_hazard = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      clear_inputs();
      total_cnt++;
      if (outs !== exp_seq[i]) $display("FAIL prio_mc cyc%0d: got %b want %b", i, outs, exp_seq[i]);
      else pass_cnt++;
    end
    $display("test_priority done");
  endtask

  task automatic test_load_use();
    ld_use_hazard = 1'b1;
    step();
    ld_use_hazard = 1'b0;
    total_cnt++;
    if (outs !== 6'b110000) $display("FAIL lu_single: got %b want 110000", outs);
    else pass_cnt++;
    step();
    total_cnt++;
    if (outs !== 6'b000000) $display("FAIL lu_single_clear: got %b want 000000", outs);
    else pass_cnt++;
    // Back-to-back requests re-arm each cycle.
    ld_use_hazard = 1'b1;
    step();
    total_cnt++;
    if (outs !== 6'b110000) $display("FAIL lu_b2b_0: got %b want 110000", outs);
    else pass_cnt++;
    step();
    ld_use_hazard = 1'b0;
    total_cnt++;
    if (outs !== 6'b110000) $display("FAIL lu_b2b_1: got %b want 110000", outs);
    else pass_cnt++;
    step();
    total_cnt++;
    if (outs !== 6'b000000) $display("FAIL lu_b2b_clear: got %b want 000000", outs);
    else pass_cnt++;
    // Multi-cycle decode without ex_valid does not mask the hazard.
    ex_is_multicycle = 1'b1;
    ld_use_hazard = 1'b1;
    step();
    clear_inputs();
    total_cnt++;
    if (outs !== 6'b110000) $display("FAIL lu_invalid_mc: got %b want 110000", outs);
    else pass_cnt++;
    step();
    $display("test_load_use done");
  endtask

  task automatic test_reset_mid_busy();
    ex_valid = 1'b1;
    ex_is_multicycle = 1'b1;
    step();
    clear_inputs();
    step();                       // now MC_BUSY with cnt = 2
    total_cnt++;
    if (outs !== 6'b100000) $display("FAIL midrst_pre: got %b want 100000", outs);
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if (outs !== 6'b000000) $display("FAIL midrst_outs: got %b want 000000", outs);
    else pass_cnt++;
    total_cnt++;
    if (pc_target !== 32'd0) $display("FAIL midrst_target: got %h want 00000000", pc_target);
    else pass_cnt++;
`ifdef EX_PERF_COUNT_EN
    total_cnt++;
    if (stall_cycles !== 32'd0 || flush_count !== 32'd0)
      $display("FAIL midrst_counters: got %0d/%0d want 0/0", stall_cycles, flush_count);
    else pass_cnt++;
`endif
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if (outs !== 6'b000000) $display("FAIL midrst_no_done cyc%0d: got %b want 000000", i, outs);
      else pass_cnt++;
    end
    $display("test_reset_mid_busy done");
  endtask

`ifdef EX_PERF_COUNT_EN
  task automatic test_perf();
    ld_use_hazard = 1'b1;         // 1 stall cycle
    step();
    clear_inputs();
    step();
    ex_valid = 1'b1;              // 3 stall cycles
    ex_is_multicycle = 1'b1;
    step();
    clear_inputs();
    for (int i = 0; i < 4; i++) step();
    ex_valid = 1'b1;              // 1 redirect
    IsBranchTaken = 1'b1;
    step();
    clear_inputs();
    step();
    total_cnt++;
    if (stall_cycles !== 32'd4) $display("FAIL perf_stall: got %0d want 4", stall_cycles);
    else pass_cnt++;
    total_cnt++;
    if (flush_count !== 32'd1) $display("FAIL perf_flush: got %0d want 1", flush_count);
    else pass_cnt++;
    $display("test_perf done");
  endtask
`endif

  initial begin
    reset = 1'b1;
    test_reset();
    test_multicycle();
    test_branch();
    test_priority();
    test_load_use();
    test_reset_mid_busy();
`ifdef EX_PERF_COUNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
